// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared font ROM widths, grant kinds and rotating pick helper
package vga_pkg;

    localparam int FONT_ADDR_W = 11;
    localparam int FONT_DATA_W = 8;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_RR,
        GNT_URGENT,
        GNT_STARVE
    } gnt_kind_e;

    // First set bit of vec[n-1:0], searching upward from ptr with wrap.
    function automatic logic [1:0] rr_pick(input logic [3:0] vec, input logic [1:0] ptr, input int n);
        logic [1:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !found && vec[2'(idx)]) begin
                pick  = 2'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rsp_pipe.sv
// rtl/rsp_pipe.sv - LAT-stage {valid, id} delay line with synchronous clear
module rsp_pipe #(
    parameter int LAT = 1,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           in_valid,
    input  logic [IDW-1:0] in_id,
    output logic           out_valid,
    output logic [IDW-1:0] out_id
);

    logic [LAT-1:0]          valid_q, valid_d;
    logic [LAT-1:0][IDW-1:0] id_q, id_d;

    always_comb begin
        valid_d = '0;
        id_d    = '0;
        if (!clr) begin
            valid_d[0] = in_valid;
            id_d[0]    = in_id;
            for (int k = 1; k < LAT; k++) begin
                valid_d[k] = valid_q[k-1];
                id_d[k]    = id_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        valid_q <= valid_d;
        id_q    <= id_d;
    end

    assign out_valid = valid_q[LAT-1];
    assign out_id    = id_q[LAT-1];

endmodule

// File: rtl/font_rom_arbiter.sv
// rtl/font_rom_arbiter.sv - starve/urgent/round-robin arbiter sharing the font ROM
module font_rom_arbiter
    import vga_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int ROM_LAT  = 1,
    parameter int MAX_WAIT = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*FONT_ADDR_W-1:0] req_addr,
    input  logic                        urgent,
    input  logic [FONT_DATA_W-1:0]      rom_data,
    output logic [NREQ-1:0]             gnt,
    output logic [FONT_ADDR_W-1:0]      rom_addr,
    output logic [NREQ-1:0]             rsp_valid,
    output logic [FONT_DATA_W-1:0]      rsp_data,
    output logic [15:0]                 busy_cnt
);

    logic [1:0]             rr_ptr_q, rr_ptr_d;
    logic [4:0]             wait_q [1:NREQ-1];
    logic [4:0]             wait_d [1:NREQ-1];
    logic [FONT_ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [15:0]            busy_q, busy_d;
    logic [3:0]             req_pad;
    logic [1:0]             gnt_idx;
    logic                   gnt_any;
    gnt_kind_e              gnt_kind;
    logic                   pipe_valid;
    logic [1:0]             pipe_id;

    always_comb begin
        req_pad             = '0;
        req_pad[NREQ-1:0]   = req;
        gnt_idx             = '0;
        gnt_kind            = GNT_NONE;
        // Descending scan so the lowest starved requester wins.
        for (int j = NREQ - 1; j >= 1; j--) begin
            if (req[j] && wait_q[j] >= 5'(MAX_WAIT)) begin
                gnt_idx  = 2'(j);
                gnt_kind = GNT_STARVE;
            end
        end
        if (gnt_kind == GNT_NONE) begin
            if (urgent && req[0]) begin
                gnt_idx  = '0;
                gnt_kind = GNT_URGENT;
            end else if (|req) begin
                gnt_idx  = rr_pick(req_pad, rr_ptr_q, NREQ);
                gnt_kind = GNT_RR;
            end
        end
        gnt_any = (gnt_kind != GNT_NONE) && !reset;

        gnt        = '0;
        rom_addr_d = rom_addr_q;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = gnt_any && (gnt_idx == 2'(i));
            if (gnt[i]) rom_addr_d = req_addr[i*FONT_ADDR_W +: FONT_ADDR_W];
        end

        rr_ptr_d = rr_ptr_q;
        if (gnt_any && gnt_kind != GNT_URGENT)
            rr_ptr_d = (int'(gnt_idx) == NREQ - 1) ? 2'd0 : gnt_idx + 2'd1;

        for (int j = 1; j < NREQ; j++) begin
            if (req[j] && !gnt[j])
                wait_d[j] = (wait_q[j] == 5'd31) ? 5'd31 : wait_q[j] + 5'd1;
            else
                wait_d[j] = '0;
        end

        busy_d = busy_q;
        if ((|req) && !gnt_any && busy_q != 16'hFFFF) busy_d = busy_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            rom_addr_q <= '0;
            busy_q     <= '0;
            for (int j = 1; j < NREQ; j++) wait_q[j] <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rom_addr_q <= rom_addr_d;
            busy_q     <= busy_d;
            for (int j = 1; j < NREQ; j++) wait_q[j] <= wait_d[j];
        end
    end

    rsp_pipe #(.LAT(ROM_LAT), .IDW(2)) u_rsp_pipe (
        .clk       (clk),
        .clr       (reset),
        .in_valid  (gnt_any),
        .in_id     (gnt_idx),
        .out_valid (pipe_valid),
        .out_id    (pipe_id)
    );

    // Gated by reset so responses to pre-reset grants never leak out.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++)
            rsp_valid[i] = pipe_valid && !reset && (pipe_id == 2'(i));
    end

    assign rom_addr = rom_addr_d;
    assign rsp_data = rom_data;
    assign busy_cnt = busy_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// tb/tb_font_rom_arbiter.sv - scoreboard bench for font_rom_arbiter at ROM_LAT 1 and 3
module tb_font_rom_arbiter;

    typedef struct {
        int         due;
        int         id;
        logic [7:0] data;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [32:0] req_addr;
    logic        urgent;
    logic [7:0]  rom_data1, rom_data3;
    logic [2:0]  gnt1, gnt3, rsp_valid1, rsp_valid3;
    logic [10:0] rom_addr1, rom_addr3;
    logic [7:0]  rsp_data1, rsp_data3;
    logic [15:0] busy1, busy3;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    int          mrr;
    int          mw [3];
    logic [10:0] maddr;
    logic [15:0] mbusy;
    int          tw [3];
    int          maxw = 0;
    logic [2:0]  g_last;
    sb_t         sb1[$];
    sb_t         sb3[$];

    function automatic logic [7:0] rom_f(input logic [10:0] a);
        return a[7:0] ^ {a[10:8], 5'b10110};
    endfunction

    always #5 clk = ~clk;

    font_rom_arbiter #(.NREQ(3), .ROM_LAT(1), .MAX_WAIT(15)) u_dut1 (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .urgent(urgent),
        .rom_data(rom_data1), .gnt(gnt1), .rom_addr(rom_addr1),
        .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .busy_cnt(busy1)
    );

    font_rom_arbiter #(.NREQ(3), .ROM_LAT(3), .MAX_WAIT(15)) u_dut3 (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .urgent(urgent),
        .rom_data(rom_data3), .gnt(gnt3), .rom_addr(rom_addr3),
        .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .busy_cnt(busy3)
    );

    logic [10:0] r1_q;
    logic [10:0] r3_q [3];
    always @(posedge clk) begin
        r1_q    <= rom_addr1;
        r3_q[0] <= rom_addr3;
        r3_q[1] <= r3_q[0];
        r3_q[2] <= r3_q[1];
    end
    assign rom_data1 = rom_f(r1_q);
    assign rom_data3 = rom_f(r3_q[2]);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        else n_pass++;
    endtask

    task automatic chk_rsp(input bit lat3, input logic [2:0] v, input logic [7:0] d);
        sb_t        e;
        logic [2:0] ev;
        ev = '0;
        e  = '{due: 0, id: 0, data: 8'h0};
        if (!lat3 && sb1.size() > 0 && sb1[0].due == cyc) begin
            e  = sb1.pop_front();
            ev = 3'b001 << e.id;
        end else if (lat3 && sb3.size() > 0 && sb3[0].due == cyc) begin
            e  = sb3.pop_front();
            ev = 3'b001 << e.id;
        end
        check(lat3 ? "rsp_valid_l3" : "rsp_valid_l1", 32'(v), 32'(ev));
        if (ev != 0) check(lat3 ? "rsp_data_l3" : "rsp_data_l1", 32'(d), 32'(e.data));
    endtask

    task automatic step();
        int         pick;
        bit         urg_g;
        int         idx;
        logic [2:0] eg;
        @(negedge clk);
        if (reset) begin
            check("gnt_rst_l1", 32'(gnt1), 32'd0);
            check("gnt_rst_l3", 32'(gnt3), 32'd0);
            sb1.delete();
            sb3.delete();
            chk_rsp(1'b0, rsp_valid1, rsp_data1);
            chk_rsp(1'b1, rsp_valid3, rsp_data3);
            mrr = 0; maddr = '0; mbusy = '0;
            for (int j = 0; j < 3; j++) begin mw[j] = 0; tw[j] = 0; end
            g_last = gnt1;
        end else begin
            pick  = -1;
            urg_g = 1'b0;
            for (int j = 1; j < 3; j++)
                if (pick < 0 && req[j] && mw[j] >= 15) pick = j;
            if (pick < 0 && urgent && req[0]) begin pick = 0; urg_g = 1'b1; end
            for (int k = 0; k < 3; k++) begin
                idx = (mrr + k) % 3;
                if (pick < 0 && req[idx]) pick = idx;
            end
            eg = (pick >= 0) ? (3'b001 << pick) : 3'b000;
            check("gnt_l1", 32'(gnt1), 32'(eg));
            check("gnt_l3", 32'(gnt3), 32'(eg));
            chk_rsp(1'b0, rsp_valid1, rsp_data1);
            chk_rsp(1'b1, rsp_valid3, rsp_data3);
            check("busy_l1", 32'(busy1), 32'(mbusy));
            check("busy_l3", 32'(busy3), 32'(mbusy));
            if (req != 0 && pick < 0) mbusy = mbusy + 16'd1;
            if (pick >= 0) begin
                maddr = req_addr[pick*11 +: 11];
                sb1.push_back('{due: cyc + 1, id: pick, data: rom_f(maddr)});
                sb3.push_back('{due: cyc + 3, id: pick, data: rom_f(maddr)});
                if (!urg_g) mrr = (pick + 1) % 3;
            end
            check("rom_addr_l1", 32'(rom_addr1), 32'(maddr));
            check("rom_addr_l3", 32'(rom_addr3), 32'(maddr));
            for (int j = 1; j < 3; j++)
                mw[j] = (req[j] && pick != j) ? ((mw[j] < 31) ? mw[j] + 1 : 31) : 0;
            for (int j = 0; j < 3; j++) begin
                tw[j] = (req[j] && !gnt1[j]) ? tw[j] + 1 : 0;
                if (tw[j] > maxw) maxw = tw[j];
            end
            g_last = gnt1;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        urgent   = 1'b0;
        req_addr = '0;
        @(posedge clk); #1;
        step(); step();
        reset = 1'b0;
        step();

        req = 3'b111;
        req_addr = {11'h243, 11'h142, 11'h041};
        repeat (9) step();

        urgent = 1'b1;
        repeat (40) step();
        check("max_wait", 32'(maxw <= 16), 32'd1);

        urgent = 1'b0;
        req = 3'b100;
        for (int k = 0; k < 8; k++) begin
            req_addr[32:22] = 11'h300 + 11'(k);
            step();
        end
        req = '0;
        repeat (4) step();

        req = 3'b010;
        step();
        req = '0;
        repeat (5) step();

        req = 3'b111;
        step();
        reset = 1'b1;
        req   = '0;
        step();
        reset = 1'b0;
        repeat (5) step();
        req = 3'b110;
        step();
        check("post_rst_gnt", 32'(g_last), 32'b010);
        req = '0;
        repeat (2) step();

        req = 3'b001;
        req_addr[10:0] = 11'h0AA;
        step();
        req = '0;
        repeat (10) step();
        check("idle_addr", 32'(rom_addr1), 32'h0AA);
        check("drain_l1", 32'(sb1.size()), 32'd0);
        check("drain_l3", 32'(sb3.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
